tdc_edge_counter: RTL and testbench

- Downstream stage of the TDC start/stop gate and ring oscillator.
- Brings the gated oscillator output (i_osc) and the start/stop strobes into the system clock domain.
- Counts oscillator rising edges inside the start-to-stop window and presents the count as one result word on a valid/ready handshake.
- Provides the coarse digital measurement for later readout logic.

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_sync_edge.sv | 36 +++
 rtl/tdc_edge_counter.sv | 134 +++++++++++++
 tb/tb_tdc_edge_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg
//   Shared types and defaults for the TDC edge-counting readout stage.
//   - tdc_state_t      : measurement FSM state (IDLE, COUNT, HOLD)
//   - DEF_CNT_W        : default edge counter width
//   - DEF_TIMEOUT_CYC  : default COUNT-state timeout in clk cycles
//   - SYNC_STAGES      : synchroniser depth for the asynchronous inputs
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } tdc_state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int SYNC_STAGES     = 2;

endpackage

// File: rtl/tdc_sync_edge.sv
// tdc_sync_edge
//   Brings one asynchronous strobe into the clk domain and flags its rising
//   edges with a one-cycle pulse.
//   Ports:
//     clk      in   system clock
//     rst_n    in   synchronous active-low reset
//     async_in in   asynchronous input
//     rise     out  registered one-cycle pulse per synchronised rising edge
//   An input that is high at clk edge N makes rise high during the cycle
//   after edge N+2 (3 clk of edge latency).
module tdc_sync_edge
    import tdc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            // Registered so downstream logic sees a clean flop output.
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/tdc_edge_counter.sv
// tdc_edge_counter
//   Counts gated ring-oscillator rising edges between a start and a stop
//   strobe and offers the count as one result on a valid/ready handshake.
//   Ports:
//     clk, rst_n   system clock, synchronous active-low reset
//     i_start      asynchronous start strobe
//     i_stop       asynchronous stop strobe
//     i_osc        asynchronous gated oscillator (must stay below clk/2)
//     o_count      measured edge count, valid while o_valid
//     o_overflow   count saturated during this measurement
//     o_timeout    measurement ended by the timer instead of stop
//     o_valid      result available (state HOLD)
//     i_ready      consumer accepts the result
//     o_busy       measurement window open (state COUNT)
//   Build option: define TDC_TIMEOUT_EN to force a stop after TIMEOUT_CYC
//   clk cycles in COUNT. Without it o_timeout is constant 0.
module tdc_edge_counter
    import tdc_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_osc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    output logic             o_timeout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       start_rise;
    logic       stop_rise;
    logic       osc_rise;
    logic       tmr_expire;
    logic       timeout_q;
    tdc_state_t state;

    tdc_sync_edge u_sync_start (.clk(clk), .rst_n(rst_n), .async_in(i_start), .rise(start_rise));
    tdc_sync_edge u_sync_stop  (.clk(clk), .rst_n(rst_n), .async_in(i_stop),  .rise(stop_rise));
    tdc_sync_edge u_sync_osc   (.clk(clk), .rst_n(rst_n), .async_in(i_osc),   .rise(osc_rise));

`ifdef TDC_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] tmr_q;

    // Held at 0 outside COUNT, so it starts from 0 on every entry.
    always_ff @(posedge clk) begin
        if (!rst_n)
            tmr_q <= '0;
        else if (state == COUNT)
            tmr_q <= tmr_q + TMR_W'(1);
        else
            tmr_q <= '0;
    end

    // The edge that would take the timer to TIMEOUT_CYC ends the window,
    // so HOLD is entered exactly TIMEOUT_CYC cycles after entering COUNT.
    assign tmr_expire = (state == COUNT) && (tmr_q == TMR_LAST);
`else
    assign tmr_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            o_count    <= '0;
            o_overflow <= 1'b0;
            timeout_q  <= 1'b0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Oscillator edges and a lone stop are ignored here.
                    if (start_rise) begin
                        o_count    <= '0;
                        o_overflow <= 1'b0;
                        timeout_q  <= 1'b0;
                        if (stop_rise) begin
                            state   <= HOLD;
                            o_valid <= 1'b1;
                        end else begin
                            state  <= COUNT;
                            o_busy <= 1'b1;
                        end
                    end
                end

                COUNT: begin
                    // An osc edge coincident with stop still counts.
                    if (osc_rise) begin
                        if (o_count == CNT_MAX)
                            o_overflow <= 1'b1;
                        else
                            o_count <= o_count + CNT_W'(1);
                    end
                    if (stop_rise || tmr_expire) begin
                        state     <= HOLD;
                        o_busy    <= 1'b0;
                        o_valid   <= 1'b1;
                        // stop wins over a timer expiring in the same cycle
                        timeout_q <= ~stop_rise;
                    end
                end

                HOLD: begin
                    // Start/stop edges here are dropped; result is frozen.
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_tdc_edge_counter.sv
// tb_tdc_edge_counter
//   Directed bench for tdc_edge_counter. Two instances share the stimulus:
//   dut (CNT_W=16) and dut4 (CNT_W=4, for saturation). Both use
//   TIMEOUT_CYC=50. Inputs are driven and outputs sampled on negedge.
module tb_tdc_edge_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_stop, i_osc, i_ready;

    logic [15:0] o_count;
    logic        o_overflow, o_timeout, o_valid, o_busy;
    logic [3:0]  o_count4;
    logic        o_overflow4, o_timeout4, o_valid4, o_busy4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tdc_edge_counter #(.CNT_W(16), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_osc(i_osc),
        .o_count(o_count), .o_overflow(o_overflow), .o_timeout(o_timeout),
        .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    tdc_edge_counter #(.CNT_W(4), .TIMEOUT_CYC(50)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_osc(i_osc),
        .o_count(o_count4), .o_overflow(o_overflow4), .o_timeout(o_timeout4),
        .o_valid(o_valid4), .i_ready(i_ready), .o_busy(o_busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic osc_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            i_osc = 1'b1; tick(2);
            i_osc = 1'b0; tick(2);
        end
    endtask

    // start, then wait until COUNT is entered (3 clk sync + 1 FSM edge)
    task automatic do_start();
        i_start = 1'b1; tick(1);
        i_start = 1'b0; tick(3);
    endtask

    task automatic do_stop();
        i_stop = 1'b1; tick(1);
        i_stop = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(o_valid), 1);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_osc = 1'b0; i_ready = 1'b0;

        // reset and idle
        tick(3);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        chk("rst_tmo", 32'(o_timeout), 0);
        rst_n = 1'b1;
        osc_pulses(10);
        tick(4);
        chk("idle_valid", 32'(o_valid), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_count", 32'(o_count), 0);

        // basic measurement: start sampled at edge N, busy first seen after N+3
        i_ready = 1'b1;
        i_start = 1'b1; tick(1);
        i_start = 1'b0; tick(2);
        chk("busy_early", 32'(o_busy), 0);
        tick(1);
        chk("busy_lat", 32'(o_busy), 1);
        osc_pulses(25);
        tick(4);
        do_stop();
        wait_valid("basic_valid");
        chk("basic_count", 32'(o_count), 25);
        chk("basic_ovf", 32'(o_overflow), 0);
        chk("basic_tmo", 32'(o_timeout), 0);
        chk("basic_busy", 32'(o_busy), 0);
        tick(1);
        chk("basic_single", 32'(o_valid), 0);

        // backpressure with a start strobe during HOLD
        i_ready = 1'b0;
        do_start();
        osc_pulses(7);
        tick(4);
        do_stop();
        wait_valid("bp_valid");
        for (int c = 0; c < 20; c++) begin
            i_start = (c == 4 || c == 5);
            chk("bp_hold_valid", 32'(o_valid), 1);
            chk("bp_hold_count", 32'(o_count), 7);
            tick(1);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        chk("bp_pre_xfer", 32'(o_valid), 1);
        tick(1);
        chk("bp_xfer", 32'(o_valid), 0);
        tick(10);
        chk("bp_no_restart_busy", 32'(o_busy), 0);
        chk("bp_no_restart_valid", 32'(o_valid), 0);

        // overflow on the 4-bit instance, then a clean follow-up
        do_start();
        osc_pulses(20);
        tick(4);
        do_stop();
        wait_valid("ovf_valid");
        chk("ovf_valid4", 32'(o_valid4), 1);
        chk("ovf_count4", 32'(o_count4), 15);
        chk("ovf_flag4", 32'(o_overflow4), 1);
        chk("ovf_count16", 32'(o_count), 20);
        chk("ovf_flag16", 32'(o_overflow), 0);
        tick(1);
        do_start();
        osc_pulses(3);
        tick(4);
        do_stop();
        wait_valid("ovf2_valid");
        chk("ovf2_count4", 32'(o_count4), 3);
        chk("ovf2_flag4", 32'(o_overflow4), 0);
        tick(1);

        // start and stop together
        i_start = 1'b1; i_stop = 1'b1; tick(1);
        i_start = 1'b0; i_stop = 1'b0;
        wait_valid("sim_valid");
        chk("sim_count", 32'(o_count), 0);
        chk("sim_busy", 32'(o_busy), 0);
        tick(1);

        // osc edge coincident with stop is counted
        do_start();
        osc_pulses(4);
        i_osc = 1'b1; i_stop = 1'b1; tick(1);
        i_stop = 1'b0; tick(1);
        i_osc = 1'b0;
        wait_valid("coin_valid");
        chk("coin_count", 32'(o_count), 5);
        tick(1);

        // reset during COUNT
        do_start();
        osc_pulses(3);
        chk("rstc_busy_pre", 32'(o_busy), 1);
        chk("rstc_count_pre", 32'(o_count), 3);
        rst_n = 1'b0; tick(1);
        chk("rstc_count", 32'(o_count), 0);
        chk("rstc_busy", 32'(o_busy), 0);
        chk("rstc_valid", 32'(o_valid), 0);
        chk("rstc_ovf", 32'(o_overflow4), 0);
        rst_n = 1'b1;
        tick(2);

        // timeout behaviour
        i_ready = 1'b0;
        do_start();
        osc_pulses(5);
`ifdef TDC_TIMEOUT_EN
        tick(29);
        chk("tmo_before", 32'(o_valid), 0);
        chk("tmo_busy_before", 32'(o_busy), 1);
        tick(1);
        chk("tmo_valid", 32'(o_valid), 1);
        chk("tmo_flag", 32'(o_timeout), 1);
        chk("tmo_count", 32'(o_count), 5);
        i_ready = 1'b1;
        tick(1);
        chk("tmo_xfer", 32'(o_valid), 0);
`else
        tick(100);
        chk("notmo_busy", 32'(o_busy), 1);
        chk("notmo_valid", 32'(o_valid), 0);
        i_ready = 1'b1;
        do_stop();
        wait_valid("notmo_stop_valid");
        chk("notmo_count", 32'(o_count), 5);
        chk("notmo_flag", 32'(o_timeout), 0);
        tick(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
